// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types, constants and helpers for the UART receive
//                path (FSM state encoding, parity type codes, defaults).
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_PRESCALE_W = 6;

    // Parity type codes as seen on PAR_TYP
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // Expected parity bit given the XOR of all data bits and the parity type
    function automatic logic expected_parity(input logic data_xor, input logic par_typ);
        logic result;
        result = data_xor;
        case (par_typ)
            PAR_EVEN: result = data_xor;
            PAR_ODD:  result = ~data_xor;
        endcase
        return result;
    endfunction

    // 2-of-3 majority used by the optional noise-filtering sampler
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sampler
//  Description : Per-bit timing for the UART receiver. Runs the oversampling
//                edge counter and the data bit counter, and produces the bit
//                value taken around the middle of each bit period.
//                Optional macro UART_RX_MAJORITY_VOTE_EN: when defined, the
//                bit value is the 2-of-3 majority of the samples at
//                P/2-2, P/2-1 and P/2; otherwise a single sample at P/2-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_s,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  run,
    input  logic                  data_phase,
    output logic                  bit_value,
    output logic                  sample_done,
    output logic                  bit_end,
    output logic                  last_bit
);

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0]  LAST_BIT_IDX = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_CNT_W-1:0]  BIT_ONE      = BIT_CNT_W'(1);
    localparam logic [PRESCALE_W-1:0] EDGE_ONE     = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] edge_cnt;
    logic [PRESCALE_W-1:0] sample_pt;
    logic [BIT_CNT_W-1:0]  bit_cnt;

    // The sample point sits half a bit in, one cycle early so the start bit
    // (counted from the cycle after the falling edge) is sampled centred.
    assign sample_pt = (prescale >> 1) - EDGE_ONE;
    assign bit_end   = run && (edge_cnt == (prescale - EDGE_ONE));
    assign last_bit  = (bit_cnt == LAST_BIT_IDX);

    // Edge counter: held at zero while idle, wraps at the end of every bit
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt <= '0;
        end else if (!run || bit_end) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + EDGE_ONE;
        end
    end

    // Data bit counter: only advances while data bits are being received
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
        end else if (!data_phase) begin
            bit_cnt <= '0;
        end else if (bit_end) begin
            bit_cnt <= bit_cnt + BIT_ONE;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic early_smp;
    logic mid_smp;

    // Three samples around the centre; the vote resolves on the third one
    always_ff @(posedge clk) begin
        if (rst) begin
            early_smp   <= 1'b1;
            mid_smp     <= 1'b1;
            bit_value   <= 1'b1;
            sample_done <= 1'b0;
        end else begin
            sample_done <= 1'b0;
            if (run && (edge_cnt == (sample_pt - EDGE_ONE))) begin
                early_smp <= rx_s;
            end
            if (run && (edge_cnt == sample_pt)) begin
                mid_smp <= rx_s;
            end
            if (run && (edge_cnt == (sample_pt + EDGE_ONE))) begin
                bit_value   <= majority3(early_smp, mid_smp, rx_s);
                sample_done <= 1'b1;
            end
        end
    end
`else
    // Single sample at the centre of the bit
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_value   <= 1'b1;
            sample_done <= 1'b0;
        end else begin
            sample_done <= 1'b0;
            if (run && (edge_cnt == sample_pt)) begin
                bit_value   <= rx_s;
                sample_done <= 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_deserializer
//  Description : UART receive path. Synchronizes the serial line, qualifies
//                the start bit, deserializes LSB-first data, optionally checks
//                even/odd parity, checks the stop bit and presents the byte
//                with a one-cycle valid strobe or one-cycle error strobes.
//                Optional macro UART_RX_MAJORITY_VOTE_EN selects 2-of-3
//                majority sampling in uart_rx_sampler.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    rx_state_t state;
    rx_state_t state_next;

    logic                  rx_meta;
    logic                  rx_s;
    logic [PRESCALE_W-1:0] prescale_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  par_fail;
    logic                  par_expected;

    logic                  bit_value;
    logic                  sample_done;
    logic                  bit_end;
    logic                  last_bit;

    // Two-flop synchronizer for the asynchronous serial line (idles high)
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX_IN;
            rx_s    <= rx_meta;
        end
    end

    // Frame configuration is frozen when a start edge leaves IDLE
    always_ff @(posedge CLK) begin
        if (RST) begin
            prescale_q <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
        end else if ((state == IDLE) && !rx_s) begin
            prescale_q <= Prescale;
            par_en_q   <= PAR_EN;
            par_typ_q  <= PAR_TYP;
        end
    end

    uart_rx_sampler #(
        .DATA_WIDTH (DATA_WIDTH),
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .clk         (CLK),
        .rst         (RST),
        .rx_s        (rx_s),
        .prescale    (prescale_q),
        .run         (state != IDLE),
        .data_phase  (state == DATA),
        .bit_value   (bit_value),
        .sample_done (sample_done),
        .bit_end     (bit_end),
        .last_bit    (last_bit)
    );

    assign par_expected = expected_parity(^shift_reg, par_typ_q);

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and strobes; all decisions happen on the last cycle of a bit
    always_comb begin
        state_next = state;
        data_valid = 1'b0;
        par_err    = 1'b0;
        stp_err    = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = bit_value ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end && last_bit) begin
                    state_next = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    par_err    = (bit_value != par_expected);
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    stp_err    = !bit_value;
                    data_valid = bit_value && !par_fail;
                    state_next = rx_s ? IDLE : START;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // A reset cycle never produces a strobe, even on a decision cycle
        if (RST) begin
            data_valid = 1'b0;
            par_err    = 1'b0;
            stp_err    = 1'b0;
        end
    end

    // LSB-first shift register: each new bit enters at the top
    always_ff @(posedge CLK) begin
        if (RST) begin
            shift_reg <= '0;
        end else if ((state == DATA) && sample_done) begin
            shift_reg <= {bit_value, shift_reg[DATA_WIDTH-1:1]};
        end
    end

    // Remember a parity failure so the stop decision can suppress data_valid
    always_ff @(posedge CLK) begin
        if (RST) begin
            par_fail <= 1'b0;
        end else if (state == START) begin
            par_fail <= 1'b0;
        end else if (par_err) begin
            par_fail <= 1'b1;
        end
    end

    // Output byte holding register, only written by an error-free frame
    always_ff @(posedge CLK) begin
        if (RST) begin
            p_data_q <= '0;
        end else if (data_valid) begin
            p_data_q <= shift_reg;
        end
    end

    // The new byte is visible during the data_valid cycle itself
    assign P_DATA = data_valid ? shift_reg : p_data_q;

endmodule
`default_nettype wire
